// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - op and FSM state encodings shared by the multiply/divide unit and the control unit
package mult_div_unit_pkg;

    localparam logic MDU_OP_MULT = 1'b0;
    localparam logic MDU_OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } mdu_state_e;

endpackage

// File: rtl/mdu_div_step.sv
// rtl/mdu_div_step.sv - one combinational restoring-division step on unsigned magnitudes
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             bit_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_o
);

    logic [WIDTH:0]   trial;
    logic [WIDTH+1:0] diff;

    always_comb begin
        trial = {rem_i, bit_i};
        diff  = {1'b0, trial} - {2'b00, divisor_i};
        // No borrow out of the subtraction means the divisor fits: keep the difference.
        q_o   = ~diff[WIDTH+1];
        rem_o = q_o ? diff[WIDTH:0] : trial;
    end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative signed multiply/divide unit feeding the HI/LO register pair
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    mdu_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   msum;
    logic [2*WIDTH-1:0] prod_u, prod_s;
    logic [WIDTH:0]   dstep_rem;
    logic             dstep_q;
    logic [WIDTH-1:0] quot_u, rem_u;
    logic             last;

    mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i     (acc_q[WIDTH-1:0]),
        .divisor_i (mag_q),
        .bit_i     (sh_q[WIDTH-1]),
        .rem_o     (dstep_rem),
        .q_o       (dstep_q)
    );

    always_comb begin
        a_neg  = a[WIDTH-1];
        b_neg  = b[WIDTH-1];
        a_mag  = a_neg ? -a : a;
        b_mag  = b_neg ? -b : b;
        // Shift-add: acc holds the upper partial product, sh shifts the multiplier out and product bits in.
        msum   = acc_q + (sh_q[0] ? {1'b0, mag_q} : '0);
        prod_u = {msum, sh_q[WIDTH-1:1]};
        prod_s = neg_q ? -prod_u : prod_u;
        quot_u = {sh_q[WIDTH-2:0], dstep_q};
        rem_u  = dstep_rem[WIDTH-1:0];
        last   = (cnt_q == '0);

        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sh_d    = sh_q;
        mag_d   = mag_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dz_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op == MDU_OP_DIV && b == '0) begin
                        state_d = S_FIN;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = (op == MDU_OP_DIV) ? S_DIV : S_MULT;
                        cnt_d   = CW'(WIDTH - 1);
                        acc_d   = '0;
                        sh_d    = a_mag;
                        mag_d   = b_mag;
                        neg_d   = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                    end
                end
            end
            S_MULT: begin
                acc_d = {1'b0, msum[WIDTH:1]};
                sh_d  = {msum[0], sh_q[WIDTH-1:1]};
                if (last) begin
                    state_d = S_FIN;
                    hi_d    = prod_s[2*WIDTH-1:WIDTH];
                    lo_d    = prod_s[WIDTH-1:0];
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DIV: begin
                acc_d = dstep_rem;
                sh_d  = quot_u;
                if (last) begin
                    state_d = S_FIN;
                    hi_d    = rneg_q ? -rem_u : rem_u;
                    lo_d    = neg_q ? -quot_u : quot_u;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            sh_q    <= '0;
            mag_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sh_q    <= sh_d;
            mag_q   <= mag_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
        end
    end

    assign busy     = (state_q == S_MULT) || (state_q == S_DIV);
    assign done     = (state_q == S_FIN);
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed checks of mult_div_unit at WIDTH=32 and WIDTH=8
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, op;
    logic [31:0] a, b, hi, lo;
    logic        busy, done, div_zero;
    logic        start8, op8;
    logic [7:0]  a8, b8, hi8, lo8;
    logic        busy8, done8, dz8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    mult_div_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
    );

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          repulse;
        logic        poke;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns at a falling edge so calls chain back-to-back.
    task automatic run32(input logic o, input logic [31:0] ia, input logic [31:0] ib,
                         input int repulse, input logic poke,
                         output logic [31:0] rhi, output logic [31:0] rlo,
                         output int lat, output int bcnt, output logic rdz,
                         output logic stable, output logic pulse1);
        logic [31:0] h0, l0;
        h0 = hi; l0 = lo;
        start = 1'b1; op = o; a = ia; b = ib;
        @(posedge clk); #1;
        start = 1'b0; op = ~o; a = $urandom; b = $urandom;
        lat = 0; bcnt = 0; stable = 1'b1; rdz = 1'b0; rhi = '0; rlo = '0; pulse1 = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (i == repulse) begin
                start = 1'b1; op = MDU_OP_MULT; a = 32'd100; b = 32'd100;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                lat = i; rhi = hi; rlo = lo; rdz = div_zero;
                break;
            end
            if (busy) bcnt++;
            if (hi !== h0 || lo !== l0) stable = 1'b0;
        end
        if (lat != 0) begin
            if (poke) begin
                start = 1'b1; op = MDU_OP_MULT; a = 32'd2; b = 32'd3;
            end
            @(negedge clk);
            start = 1'b0;
            pulse1 = !done && !div_zero;
            if (poke) begin
                chk("fin_start_ignored_busy", busy, 1'b0);
                @(negedge clk);
                chk("fin_start_not_queued", busy, 1'b0);
            end
        end
    endtask

    task automatic run8(input logic o, input logic [7:0] x, input logic [7:0] y,
                        output logic [7:0] rh, output logic [7:0] rl, output int lat);
        start8 = 1'b1; op8 = o; a8 = x; b8 = y;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        lat = 0; rh = '0; rl = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done8) begin
                lat = i; rh = hi8; rl = lo8;
                break;
            end
        end
        @(negedge clk);
    endtask

    function automatic void model8(input logic o, input logic [7:0] x, input logic [7:0] y,
                                   output logic [7:0] mh, output logic [7:0] ml);
        int sx, sy, p, q, r;
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (o == MDU_OP_MULT) begin
            p  = sx * sy;
            mh = p[15:8];
            ml = p[7:0];
        end else begin
            q  = sx / sy;
            r  = sx % sy;
            mh = r[7:0];
            ml = q[7:0];
        end
    endfunction

    initial begin
        logic [31:0] rhi, rlo;
        logic [7:0]  rh8, rl8, mh8, ml8;
        logic        rdz, stable, pulse1, seen;
        int          lat, bcnt;
        logic [7:0]  px[8];
        logic [7:0]  py[8];

        vecs[0]  = '{MDU_OP_MULT, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 0, 1'b0};
        vecs[1]  = '{MDU_OP_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0, 1'b0};
        vecs[2]  = '{MDU_OP_DIV,  32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 0, 1'b0};
        vecs[3]  = '{MDU_OP_DIV,  32'h00000005, 32'h00000000, 32'h00000001, 32'hFFFFFFFD, 1'b1, 0, 1'b0};
        vecs[4]  = '{MDU_OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 0, 1'b0};
        vecs[5]  = '{MDU_OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 0, 1'b0};
        vecs[6]  = '{MDU_OP_MULT, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 5, 1'b0};
        vecs[7]  = '{MDU_OP_MULT, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 0, 1'b0};
        vecs[8]  = '{MDU_OP_DIV,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0, 0, 1'b1};
        vecs[9]  = '{MDU_OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 0, 1'b0};
        vecs[10] = '{MDU_OP_DIV,  32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 1'b0, 0, 1'b0};
        vecs[11] = '{MDU_OP_DIV,  32'h00000003, 32'h0000000A, 32'h00000003, 32'h00000000, 1'b0, 0, 1'b0};

        px = '{8'd7,  8'hF9, 8'd7,  8'h80, 8'h80, 8'h7F, 8'hFB, 8'd100};
        py = '{8'hFD, 8'd2,  8'hFE, 8'hFF, 8'h80, 8'h80, 8'd3,  8'd7};

        reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        start8 = 1'b0; op8 = 1'b0; a8 = '0; b8 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_div_zero", div_zero, 1'b0);
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        chk("reset_busy8", busy8, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run32(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].repulse, vecs[i].poke,
                  rhi, rlo, lat, bcnt, rdz, stable, pulse1);
            chk($sformatf("v%0d_hi", i), rhi, vecs[i].hi);
            chk($sformatf("v%0d_lo", i), rlo, vecs[i].lo);
            chk($sformatf("v%0d_div_zero", i), rdz, vecs[i].dz);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].dz ? 1 : 33);
            chk($sformatf("v%0d_busy_cycles", i), bcnt, vecs[i].dz ? 0 : 32);
            chk($sformatf("v%0d_hilo_stable", i), stable, 1'b1);
            chk($sformatf("v%0d_done_one_cycle", i), pulse1, 1'b1);
        end

        // Reset in the middle of a divide must abort with no done pulse.
        start = 1'b1; op = MDU_OP_DIV; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_div_busy", busy, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("abort_no_done", seen, 1'b0);

        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 2; k++) begin
                model8(k[0], px[i], py[i], mh8, ml8);
                run8(k[0], px[i], py[i], rh8, rl8, lat);
                chk($sformatf("w8_p%0d_op%0d_hi", i, k), rh8, mh8);
                chk($sformatf("w8_p%0d_op%0d_lo", i, k), rl8, ml8);
                chk($sformatf("w8_p%0d_op%0d_latency", i, k), lat, 9);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
